// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: GF(2^8) constants, widths, FSM encoding, xtime.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

    localparam logic [7:0] GF_POLY = 8'h1B;   // x^8 + x^4 + x^3 + x + 1, low byte
    localparam int         BYTE_W  = 8;
    localparam int         COL_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_HOLD    = 2'd2
    } fsm_t;

    // Multiply by 2 in GF(2^8): shift left, fold the overflow bit back in.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
        return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// One AES column through MixColumns (inv=0) or InvMixColumns (inv=1), purely combinational.
// Latency: 0 cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   col  - input column, byte 0 in bits [31:24]
//   inv  - 1 selects the inverse coefficient matrix
//   res  - transformed column, same byte order
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col,
    input  logic             inv,
    output logic [COL_W-1:0] res
);

    logic [BYTE_W-1:0] a  [4];
    logic [BYTE_W-1:0] m2 [4];
    logic [BYTE_W-1:0] m4 [4];
    logic [BYTE_W-1:0] m8 [4];
    logic [BYTE_W-1:0] m3 [4];
    logic [BYTE_W-1:0] m9 [4];
    logic [BYTE_W-1:0] mb [4];
    logic [BYTE_W-1:0] md [4];
    logic [BYTE_W-1:0] me [4];
    logic [BYTE_W-1:0] fw [4];
    logic [BYTE_W-1:0] iv [4];

    // Every coefficient is composed from the chain a, 2a, 4a, 8a.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[COL_W-1-BYTE_W*i -: BYTE_W];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m3[i] = m2[i] ^ a[i];
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
    end

    // Circulant matrices: each output row is the previous row rotated right by one.
    assign fw[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
    assign fw[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
    assign fw[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
    assign fw[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];

    assign iv[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign iv[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign iv[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign iv[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

    assign res = inv ? {iv[0], iv[1], iv[2], iv[3]} : {fw[0], fw[1], fw[2], fw[3]};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns over NUM_COLS columns, one column per cycle through a shared unit.
// Latency: out_valid rises NUM_COLS cycles after the accept edge.
// Backpressure: result held in HOLD until out_ready; no new accept until back in IDLE.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - input handshake; inv_i and state_i captured on accept
//   out_valid/out_ready - output handshake; state_o is the registered state
//   busy                - high while computing or holding a result
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NUM_COLS    = 4,
    parameter int SUPPORT_INV = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      inv_i,
    input  logic [COL_W*NUM_COLS-1:0] state_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COL_W*NUM_COLS-1:0] state_o,
    output logic                      busy
);

    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int SW = COL_W * NUM_COLS;

    fsm_t             state;
    fsm_t             nxt;
    logic [CW-1:0]    col_cnt;
    logic             mode;
    logic [SW-1:0]    data;
    logic [COL_W-1:0] cur_col;
    logic [COL_W-1:0] new_col;
    logic             last_col;

    assign last_col = (col_cnt == CW'(NUM_COLS - 1));
    assign state_o  = data;

    always_comb begin
        cur_col = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_cnt == CW'(c)) begin
                cur_col = data[COL_W*(NUM_COLS-c)-1 -: COL_W];
            end
        end
    end

    mix_column_unit u_mcu (
        .col (cur_col),
        .inv (mode),
        .res (new_col)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                if (last_col) nxt = ST_HOLD;
            end
            ST_HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, then rewrite one column per cycle in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt <= '0;
            mode    <= 1'b0;
            data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data    <= state_i;
                        mode    <= (SUPPORT_INV != 0) && inv_i;
                        col_cnt <= '0;
                    end
                end
                ST_COMPUTE: begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (col_cnt == CW'(c)) begin
                            data[COL_W*(NUM_COLS-c)-1 -: COL_W] <= new_col;
                        end
                    end
                    // Parks on the last index rather than wrapping past NUM_COLS-1.
                    if (!last_col) col_cnt <= col_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         in_valid4, out_ready4, inv4;
    logic [127:0] state4;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] res4;

    logic         in_valid1, out_ready1, inv1;
    logic [31:0]  state1;
    logic         in_ready1, out_valid1, busy1;
    logic [31:0]  res1;
    logic         in_ready1n, out_valid1n, busy1n;
    logic [31:0]  res1n;

    int compares = 0;
    int errs     = 0;

    logic [127:0] held;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;

    always #5 clk = ~clk;

    mix_columns_seq #(.NUM_COLS(4), .SUPPORT_INV(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .inv_i(inv4), .state_i(state4), .out_valid(out_valid4), .out_ready(out_ready4),
        .state_o(res4), .busy(busy4)
    );

    mix_columns_seq #(.NUM_COLS(1), .SUPPORT_INV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .inv_i(inv1), .state_i(state1), .out_valid(out_valid1), .out_ready(out_ready1),
        .state_o(res1), .busy(busy1)
    );

    mix_columns_seq #(.NUM_COLS(1), .SUPPORT_INV(0)) u1n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1n),
        .inv_i(inv1), .state_i(state1), .out_valid(out_valid1n), .out_ready(out_ready1),
        .state_o(res1n), .busy(busy1n)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compares++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one active edge, then land on the sampling (falling) edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; inv4 = 1'b0; state4 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; inv1 = 1'b0; state1 = '0;
        @(negedge clk);
        step();

        // Reset values
        chk("rst_out_valid", {127'd0, out_valid4}, 128'd0);
        chk("rst_busy",      {127'd0, busy4},      128'd0);
        chk("rst_in_ready",  {127'd0, in_ready4},  128'd1);
        chk("rst_state_o",   res4,                 128'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {127'd0, in_ready4}, 128'd1);
        chk("post_rst_state_o",  res4,                128'd0);

        // Forward, 4 columns, in_valid kept high and inputs scrambled after accept
        in_valid4 = 1'b1; state4 = FWD_IN; inv4 = 1'b0;
        step();
        state4 = {4{32'hffffffff}}; inv4 = 1'b1;
        chk("fwd4_busy_c0",     {127'd0, busy4},     128'd1);
        chk("fwd4_in_ready_c0", {127'd0, in_ready4}, 128'd0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("fwd4_no_valid_early", {127'd0, out_valid4}, 128'd0);
        end
        step();
        in_valid4 = 1'b0;
        chk("fwd4_valid_at_4", {127'd0, out_valid4}, 128'd1);
        chk("fwd4_result",     res4,                 FWD_OUT);
        held = res4;

        // Backpressure: five more cycles in HOLD
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid",    {127'd0, out_valid4}, 128'd1);
            chk("bp_stable",   res4,                 FWD_OUT);
            chk("bp_in_ready", {127'd0, in_ready4},  128'd0);
        end

        // Release and present the inverse vector at the same time
        out_ready4 = 1'b1; in_valid4 = 1'b1; state4 = INV_IN; inv4 = 1'b1;
        step();
        chk("release_in_ready",  {127'd0, in_ready4},  128'd1);
        chk("release_out_valid", {127'd0, out_valid4}, 128'd0);
        chk("idle_holds_result", res4,                 FWD_OUT);
        step();
        in_valid4 = 1'b0; state4 = '0; inv4 = 1'b0;
        chk("inv4_accepted", {127'd0, busy4}, 128'd1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("inv4_no_valid_early", {127'd0, out_valid4}, 128'd0);
        end
        step();
        chk("inv4_valid_at_4", {127'd0, out_valid4}, 128'd1);
        chk("inv4_result",     res4,                 INV_OUT);
        step();
        chk("inv4_back_idle", {127'd0, in_ready4}, 128'd1);

        // Reset after two columns of computation
        in_valid4 = 1'b1; state4 = FWD_IN; inv4 = 1'b0;
        step();
        in_valid4 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("abort_out_valid", {127'd0, out_valid4}, 128'd0);
        chk("abort_in_ready",  {127'd0, in_ready4},  128'd1);
        chk("abort_state_o",   res4,                 128'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("abort_no_pulse", {127'd0, out_valid4}, 128'd0);
        end
        in_valid4 = 1'b1; state4 = INV_IN; inv4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step(); step(); step(); step();
        chk("fresh_valid",  {127'd0, out_valid4}, 128'd1);
        chk("fresh_result", res4,                 INV_OUT);

        // Single column, forward, both variants
        in_valid1 = 1'b1; state1 = 32'hdb135345; inv1 = 1'b0;
        step();
        in_valid1 = 1'b0;
        chk("c1_busy", {127'd0, busy1}, 128'd1);
        step();
        chk("c1_valid",   {127'd0, out_valid1}, 128'd1);
        chk("c1_result",  {96'd0, res1},        {96'd0, 32'h8e4da1bc});
        chk("c1n_result", {96'd0, res1n},       {96'd0, 32'h8e4da1bc});
        step();

        // inv_i=1: forward-only instance ignores it
        in_valid1 = 1'b1; state1 = 32'hdb135345; inv1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        chk("noinv_valid",  {127'd0, out_valid1n}, 128'd1);
        chk("noinv_result", {96'd0, res1n},        {96'd0, 32'h8e4da1bc});
        step();

        // Single column inverse on the full instance
        in_valid1 = 1'b1; state1 = 32'h8e4da1bc; inv1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        chk("c1_inv_valid",  {127'd0, out_valid1}, 128'd1);
        chk("c1_inv_result", {96'd0, res1},        {96'd0, 32'hdb135345});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
        $finish;
    end

endmodule
